// File: rtl/gray_ptr_rx_if.sv
// Bus between the foreign-domain Gray pointer source and the local-domain receiver.
interface gray_ptr_rx_if #(
    parameter int W = 4
);
    logic [W-1:0] gray_in;
    logic         err_clr;
    logic [W-1:0] gray_sync;
    logic [W-1:0] bin_out;
    logic [W-1:0] adv;
    logic         changed;
    logic         code_err;

    modport master (
        output gray_in, err_clr,
        input  gray_sync, bin_out, adv, changed, code_err
    );

    modport slave (
        input  gray_in, err_clr,
        output gray_sync, bin_out, adv, changed, code_err
    );
endinterface

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray-coded pointer crossing: synchronizes the foreign pointer,
// decodes it to binary, reports the modular advance and flags codes illegal for MOD.
module gray_ptr_rx #(
    parameter int MOD         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    gray_ptr_rx_if.slave bus
);
    localparam int         W     = $clog2(MOD);
    localparam logic [W:0] MOD_W = (W+1)'(MOD);

    logic [W-1:0] r_sync [SYNC_STAGES];
    logic [W-1:0] r_bin;
    logic [W-1:0] r_adv;
    logic         r_changed;
    logic         r_code_err;

    logic [W-1:0] w_gray;
    logic [W-1:0] w_bin;
    logic         w_legal;
    logic [W-1:0] w_adv;

    // Plain flop chain; only stage 0 ever samples the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_gray = r_sync[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_decode
        assign w_bin[i] = ^w_gray[W-1:i];
    end

    assign w_legal = ({1'b0, w_bin} < MOD_W);

    always_comb begin
        w_adv = '0;
        if (w_bin >= r_bin) begin
            w_adv = W'({1'b0, w_bin} - {1'b0, r_bin});
        end else begin
            w_adv = W'({1'b0, w_bin} + MOD_W - {1'b0, r_bin});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin      <= '0;
            r_adv      <= '0;
            r_changed  <= 1'b0;
            r_code_err <= 1'b0;
        end else begin
            if (!w_legal) begin
                r_adv      <= '0;
                r_changed  <= 1'b0;
                r_code_err <= 1'b1;
            end else begin
                if (bus.err_clr) begin
                    r_code_err <= 1'b0;
                end
                if (w_bin != r_bin) begin
                    r_bin     <= w_bin;
                    r_adv     <= w_adv;
                    r_changed <= 1'b1;
                end else begin
                    r_adv     <= '0;
                    r_changed <= 1'b0;
                end
            end
        end
    end

    assign bus.gray_sync = w_gray;
    assign bus.bin_out   = r_bin;
    assign bus.adv       = r_adv;
    assign bus.changed   = r_changed;
    assign bus.code_err  = r_code_err;
endmodule

// File: doc/gray_ptr_rx.md
Name: gray_ptr_rx

Overview:
Receive side of a Gray-coded pointer crossing, for the async FIFO.
- Takes a Gray pointer produced by the MOD-wrapping Gray counter in the foreign clock domain.
- Synchronizes it into clk through a flop chain, decodes it to binary and reports how far the pointer advanced.
- Flags codes that are illegal for MOD.
- Its outputs feed full/empty comparison logic in the local domain.

Parameters:
MOD, 16, pointer modulus; legal pointer values are 0..MOD-1. W = $clog2(MOD).
SYNC_STAGES, 2, synchronizer depth; legal range 2..4.

Ports:
clk  input  1  local clock
rst  input  1  reset, asynchronous, active-high
gray_in  input  W  Gray pointer from foreign domain; asynchronous to clk
err_clr  input  1  clears code_err
gray_sync  output  W  last synchronizer stage (Gray)
bin_out  output  W  registered binary value of the last legal synchronized pointer
adv  output  W  pointer advance, mod MOD, since the previous accepted value
changed  output  1  one-cycle pulse when bin_out updates
code_err  output  1  sticky illegal-code flag

Behaviour:
- Reset (async assert, sync release on clk):
  - All sync stages = 0, gray_sync = 0, bin_out = 0, adv = 0, changed = 0, code_err = 0.
  - Reset mid-operation discards all in-flight sync data.
- Synchronizer:
  - gray_in is captured by stage 1 on each rising clk and shifts one stage per edge.
  - gray_sync is the last stage.
  - No logic between stages; stage 1 is the only flop to sample gray_in.
- Decode (combinational from gray_sync):
  - d[W-1] = g[W-1]; d[i] = d[i+1] ^ g[i] for i = W-2 down to 0.
- Legality: d >= MOD is illegal. This is only possible when MOD is not a power of 2.
- Output register, updated every clk edge:
  - Legal d, d != bin_out: bin_out <= d; adv <= (d >= bin_out) ? d - bin_out : d + MOD - bin_out, computed in W+1 bits and truncated to W; changed <= 1.
  - Legal d, d == bin_out: bin_out holds; adv <= 0; changed <= 0.
  - Illegal d: bin_out holds; adv <= 0; changed <= 0; code_err <= 1.
- Latency: a stable gray_in change appears on gray_sync after SYNC_STAGES edges, and on bin_out/adv/changed after SYNC_STAGES+1 edges.
- Wrap-around:
  - Transition MOD-1 -> 0 yields adv = 1.
  - This holds even when the source Gray codes differ in more than one bit (non-power-of-2 MOD).
  - That case is legal here; the source side must hold the pointer stable long enough.
- Multi-step advance: when the source advances k steps between local samples, a single update reports adv = k (k < MOD). Downstream must accumulate adv, not count changed pulses.
- code_err:
  - Set by any illegal decoded value.
  - Cleared by err_clr on a clk edge.
  - Set has priority when both occur in the same cycle.
- Outputs are all registered; no combinational path from gray_in or err_clr to any output.

Test Plan:
- Reset, then gray_in held at 0 -> all outputs 0, and changed never pulses over 20 cycles.
- MOD=16, SYNC_STAGES=2, gray_in stepped through gray(1), gray(2), gray(3), 10 cycles apart -> bin_out 1, 2, 3, each appearing 3 edges after the change; adv = 1 and changed pulsed for exactly 1 cycle each.
- MOD=16, gray_in jumps gray(5) -> gray(8) (0111 -> 1100) -> bin_out 8, adv = 3. Then gray(15) -> gray(0) -> adv = 1.
- MOD=12, gray_in goes gray(11) = 1110 -> 0000 -> bin_out 0, adv = 1, code_err stays 0.
- MOD=12, gray_in forced to 1011 (decodes 13) -> bin_out holds previous value, adv 0, code_err 1 and still 1 after gray_in returns legal. err_clr pulsed -> code_err 0. err_clr asserted while an illegal code is present -> code_err stays 1.
- rst asserted mid-stream (bin_out = 7, gray_in still gray(7)) -> outputs 0 immediately. After release, bin_out = 7, adv = 7, changed pulse 3 edges later.
